mux6_reg: RTL and testbench
===========================

# mux6_reg

Six-input, one-bit selector with a zero-default for out-of-range selects. It provides a purely combinational output for datapath use, plus a registered copy and an out-of-range flag for timing-closed consumers. It sits as a leaf cell in the shifter datapath, where generated muxes of arbitrary width are composed from this and smaller mux cells.

## Interface
- No parameters (width fixed at 6 data inputs, 3-bit select).
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous, active-low reset
- a  input  6  data inputs; a[k] is selected when s == k
- s  input  3  select
- y  output  1  combinational selected bit
- y_q  output  1  registered copy of y
- sel_invalid  output  1  combinational; high when s >= 6
- sel_invalid_q  output  1  registered copy of sel_invalid

## Operation
- Combinational path (no clock involvement):
  - s in 0..5: y = a[s].
  - s in 6..7: y = 0, regardless of a. y is never X/Z for known inputs.
  - sel_invalid = s[2] & s[1].
- Required structure: a 4:1 stage on a[3:0] (s[1:0]) and a 2:1 stage on a[5:4] (s[0]).
  - Final 2:1 is steered by s[2].
  - Output is forced to 0 when sel_invalid is high.
  - Each stage is built from 2:1 cells so wider generated muxes reuse the same leaves.
- Registered path: on each rising clk, y_q <= y and sel_invalid_q <= sel_invalid.
- No enable; registers update every cycle.
- Width rules: s is unsigned 3-bit; no sign extension; a is indexed LSB = a[0].

## Timing
- y and sel_invalid respond to any change of a or s within the same delta/propagation. There is zero-cycle latency.
- y_q and sel_invalid_q have 1-cycle latency, reflecting the a/s values sampled at the rising clk edge.
- Reset:
  - rst_n low immediately (asynchronously) forces y_q = 0 and sel_invalid_q = 0.
  - Reset held low keeps them at 0 across clock edges.
  - Reset has no effect on y or sel_invalid.
- Reset deassertion is synchronous to the next rising clk. The first capture occurs at the first rising edge with rst_n high.
- Reset asserted mid-operation discards the captured value; there is no recovery state.
- Simultaneous change of a and s: y settles to a_new[s_new]; no glitch requirement beyond final value correctness.

## Test plan
- a = 6'b101010, sweep s = 0..5 -> y = 0,1,0,1,0,1; sel_invalid = 0 each step.
- a = 6'b111111, s = 6 then 7 -> y = 0 and sel_invalid = 1 both times. Then a = 6'b000000 -> y still 0.
- 1024 random (a, s) pairs, each checked 1 time unit after apply -> y === (s<6 ? a[s] : 0).
  - Use 4-state compare; error count must be 0 to report SUCCESS.
- Clocked: set a = 6'b000100, s = 2 before edge -> y_q = 1 after that edge. Change s = 7 -> y_q = 1 until the next edge, then y_q = 0 and sel_invalid_q = 1.
- Async reset mid-run: y_q = 1, drop rst_n between edges -> y_q = 0 immediately while y is unchanged. Raise rst_n -> y_q follows y at the next rising edge.

Source files
------------

// File: rtl/mux6_reg_if.sv
// rtl/mux6_reg_if.sv - signal bundle for the six-input selector leaf cell
interface mux6_reg_if;
    logic [5:0] a;
    logic [2:0] s;
    logic       y;
    logic       y_q;
    logic       sel_invalid;
    logic       sel_invalid_q;

    // Driver side: supplies data and select, observes results
    modport master (
        output a,
        output s,
        input  y,
        input  y_q,
        input  sel_invalid,
        input  sel_invalid_q
    );

    // Cell side: consumes data and select, produces results
    modport slave (
        input  a,
        input  s,
        output y,
        output y_q,
        output sel_invalid,
        output sel_invalid_q
    );
endinterface

// File: rtl/mux6_reg.sv
// rtl/mux6_reg.sv - six-input one-bit selector with zero default and registered copies

// Two-input leaf shared by every stage so wider generated muxes reuse it
module mux6_reg_mux2 (
    input  logic d0,
    input  logic d1,
    input  logic sel,
    output logic y
);
    assign y = sel ? d1 : d0;
endmodule

module mux6_reg (
    input  logic          clk,
    input  logic          rst_n,
    mux6_reg_if.slave     bus
);
    // Stage outputs of the 2:1 tree
    logic pair_lo;      // a[1:0] by s[0]
    logic pair_hi;      // a[3:2] by s[0]
    logic quad;         // a[3:0] by s[1:0]
    logic pair_top;     // a[5:4] by s[0]
    logic tree;         // final pick by s[2]
    logic invalid;

    // Select values 6 and 7 are the only ones with both upper bits set
    assign invalid = bus.s[2] & bus.s[1];

    // 4:1 stage on a[3:0], built as two 2:1 levels
    mux6_reg_mux2 u_pair_lo (
        .d0  (bus.a[0]),
        .d1  (bus.a[1]),
        .sel (bus.s[0]),
        .y   (pair_lo)
    );

    mux6_reg_mux2 u_pair_hi (
        .d0  (bus.a[2]),
        .d1  (bus.a[3]),
        .sel (bus.s[0]),
        .y   (pair_hi)
    );

    mux6_reg_mux2 u_quad (
        .d0  (pair_lo),
        .d1  (pair_hi),
        .sel (bus.s[1]),
        .y   (quad)
    );

    // 2:1 stage on a[5:4]
    mux6_reg_mux2 u_pair_top (
        .d0  (bus.a[4]),
        .d1  (bus.a[5]),
        .sel (bus.s[0]),
        .y   (pair_top)
    );

    // Final 2:1 steered by s[2]; s=6/7 land here with pair_top garbage,
    // so the invalid mask below is what guarantees the zero default
    mux6_reg_mux2 u_final (
        .d0  (quad),
        .d1  (pair_top),
        .sel (bus.s[2]),
        .y   (tree)
    );

    assign bus.y           = tree & ~invalid;
    assign bus.sel_invalid = invalid;

    // Capture the combinational results every cycle; reset clears them at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.y_q           <= 1'b0;
            bus.sel_invalid_q <= 1'b0;
        end else begin
            bus.y_q           <= bus.y;
            bus.sel_invalid_q <= invalid;
        end
    end
endmodule

// File: tb/tb_mux6_reg.sv
// tb/tb_mux6_reg.sv - randomized self-checking bench for mux6_reg
module tb_mux6_reg;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    mux6_reg_if bus ();

    mux6_reg dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: pick bit s of a when s names one of the six inputs, else 0
    function automatic logic ref_y(input logic [5:0] a, input logic [2:0] s);
        int idx;
        idx = int'(s);
        if (idx < 6) return a[idx];
        return 1'b0;
    endfunction

    function automatic logic ref_inv(input logic [2:0] s);
        return int'(s) >= 6;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        bus.a = 6'b000001;
        bus.s = 3'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (bus.y_q !== 1'b0) begin
            bad++;
            $display("FAIL reset_y_q got=%b want=0", bus.y_q);
        end
        total++;
        if (bus.sel_invalid_q !== 1'b0) begin
            bad++;
            $display("FAIL reset_sel_invalid_q got=%b want=0", bus.sel_invalid_q);
        end
        total++;
        if (bus.y !== 1'b1) begin
            bad++;
            $display("FAIL reset_comb_y got=%b want=1", bus.y);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_pattern();
        logic [5:0] want;
        want = 6'b101010;
        bus.a = 6'b101010;
        for (int k = 0; k < 6; k++) begin
            bus.s = 3'(k);
            #1;
            total++;
            if (bus.y !== want[k]) begin
                bad++;
                $display("FAIL pattern_y s=%0d got=%b want=%b", k, bus.y, want[k]);
            end
            total++;
            if (bus.sel_invalid !== 1'b0) begin
                bad++;
                $display("FAIL pattern_inv s=%0d got=%b want=0", k, bus.sel_invalid);
            end
        end
    endtask

    task automatic test_invalid_select();
        bus.a = 6'b111111;
        for (int k = 6; k < 8; k++) begin
            bus.s = 3'(k);
            #1;
            total++;
            if (bus.y !== 1'b0) begin
                bad++;
                $display("FAIL invalid_y s=%0d got=%b want=0", k, bus.y);
            end
            total++;
            if (bus.sel_invalid !== 1'b1) begin
                bad++;
                $display("FAIL invalid_flag s=%0d got=%b want=1", k, bus.sel_invalid);
            end
        end
        bus.a = 6'b000000;
        #1;
        total++;
        if (bus.y !== 1'b0) begin
            bad++;
            $display("FAIL invalid_zero_a got=%b want=0", bus.y);
        end
    endtask

    task automatic test_random_comb();
        int errs;
        errs = 0;
        for (int i = 0; i < 1024; i++) begin
            bus.a = 6'($urandom);
            bus.s = 3'($urandom_range(0, 7));
            #1;
            total++;
            if (bus.y !== ref_y(bus.a, bus.s) || bus.sel_invalid !== ref_inv(bus.s)) begin
                bad++;
                if (errs < 10)
                    $display("FAIL random_comb a=%b s=%0d got y=%b inv=%b want y=%b inv=%b",
                             bus.a, bus.s, bus.y, bus.sel_invalid,
                             ref_y(bus.a, bus.s), ref_inv(bus.s));
                errs++;
            end
        end
    endtask

    task automatic test_clocked();
        @(negedge clk);
        bus.a = 6'b000100;
        bus.s = 3'd2;
        @(posedge clk);
        #1;
        total++;
        if (bus.y_q !== 1'b1) begin
            bad++;
            $display("FAIL clocked_capture got=%b want=1", bus.y_q);
        end
        bus.s = 3'd7;
        #1;
        total++;
        if (bus.y_q !== 1'b1 || bus.y !== 1'b0) begin
            bad++;
            $display("FAIL clocked_hold got y_q=%b y=%b want y_q=1 y=0", bus.y_q, bus.y);
        end
        @(posedge clk);
        #1;
        total++;
        if (bus.y_q !== 1'b0 || bus.sel_invalid_q !== 1'b1) begin
            bad++;
            $display("FAIL clocked_invalid got y_q=%b inv_q=%b want 0 1",
                     bus.y_q, bus.sel_invalid_q);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        bus.a = 6'b000100;
        bus.s = 3'd2;
        @(posedge clk);
        #1;
        total++;
        if (bus.y_q !== 1'b1) begin
            bad++;
            $display("FAIL areset_pre got=%b want=1", bus.y_q);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.y_q !== 1'b0 || bus.y !== 1'b1) begin
            bad++;
            $display("FAIL areset_drop got y_q=%b y=%b want y_q=0 y=1", bus.y_q, bus.y);
        end
        @(posedge clk);
        #1;
        total++;
        if (bus.y_q !== 1'b0) begin
            bad++;
            $display("FAIL areset_held got=%b want=0", bus.y_q);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (bus.y_q !== 1'b0) begin
            bad++;
            $display("FAIL areset_release_early got=%b want=0", bus.y_q);
        end
        @(posedge clk);
        #1;
        total++;
        if (bus.y_q !== 1'b1) begin
            bad++;
            $display("FAIL areset_first_capture got=%b want=1", bus.y_q);
        end
    endtask

    task automatic test_back_to_back();
        logic exp_y;
        logic exp_inv;
        int   errs;
        errs = 0;
        @(negedge clk);
        bus.a = 6'($urandom);
        bus.s = 3'($urandom_range(0, 7));
        exp_y   = ref_y(bus.a, bus.s);
        exp_inv = ref_inv(bus.s);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            total++;
            if (bus.y_q !== exp_y || bus.sel_invalid_q !== exp_inv) begin
                bad++;
                if (errs < 10)
                    $display("FAIL back_to_back i=%0d got y_q=%b inv_q=%b want %b %b",
                             i, bus.y_q, bus.sel_invalid_q, exp_y, exp_inv);
                errs++;
            end
            bus.a = 6'($urandom);
            bus.s = 3'($urandom_range(0, 7));
            exp_y   = ref_y(bus.a, bus.s);
            exp_inv = ref_inv(bus.s);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.a = 6'b0;
        bus.s = 3'd0;
        test_reset();
        test_pattern();
        test_invalid_select();
        test_random_comb();
        test_clocked();
        test_async_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
